// File: rtl/image_loader.sv
// rtl/image_loader.sv - streaming pixel loader that binarises a raster frame into a packed image
//
// Accepts one grayscale pixel per beat in raster order and thresholds it.
// The result is written into a packed N-bit image, where N = IMG_DIM*IMG_DIM.
// The image is held stable until the consumer acknowledges it.
//
// Optional feature macro: IMAGE_LOADER_STATS_EN adds frame_cnt / err_cnt.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   pix_data     grayscale pixel, raster order
//   pix_valid    pix_data/pix_last valid this cycle
//   pix_last     final pixel of a frame
//   pix_ready    loader accepts a beat this cycle (LOAD state)
//   image_out    packed binary image, pixel k = row*IMG_DIM+col at bit k
//   image_valid  image_out holds a complete frame (HOLD state)
//   image_ack    consumer has latched image_out; frees the buffer
//   frame_err    one-cycle pulse on a framing error
//   frame_cnt    (stats) completed frames, saturating
//   err_cnt      (stats) framing errors, saturating
module image_loader #(
  parameter int IMG_DIM   = 28,
  parameter int PIX_W     = 8,
  parameter int THRESHOLD = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_W-1:0]           pix_data,
  input  logic                       pix_valid,
  input  logic                       pix_last,
  output logic                       pix_ready,
  output logic [IMG_DIM*IMG_DIM-1:0] image_out,
  output logic                       image_valid,
  input  logic                       image_ack,
`ifdef IMAGE_LOADER_STATS_EN
  output logic                       frame_err,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                err_cnt
`else
  output logic                       frame_err
`endif
);

  localparam int N  = IMG_DIM * IMG_DIM;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PIX_W-1:0] THR      = PIX_W'(THRESHOLD);
  localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);

  typedef enum logic {LOAD, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic          accept;
  logic          at_end;

  // Handshake is a pure decode of the state register, independent of pix_valid.
  assign pix_ready   = (state == LOAD);
  assign image_valid = (state == HOLD);
  assign accept      = pix_valid && pix_ready;
  assign at_end      = (cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          if (at_end) begin
            // The N-th pixel always completes the frame.
            // A missing pix_last is only flagged as an error.
            state_nxt = HOLD;
            cnt_nxt   = '0;
            err_nxt   = !pix_last;
          end else if (pix_last) begin
            // Short frame: drop it and restart at pixel 0.
            cnt_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (image_ack) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      frame_err <= 1'b0;
      image_out <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= err_nxt;
      if (accept) begin
        image_out[cnt] <= (pix_data >= THR);
      end
    end
  end

`ifdef IMAGE_LOADER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (state == LOAD && state_nxt == HOLD && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (frame_err && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - directed self-checking bench for image_loader
module tb_image_loader;

  localparam int N = 784;

  logic           clk;
  logic           rst;
  logic [7:0]     pix_data;
  logic           pix_valid;
  logic           pix_last;
  logic           pix_ready;
  logic [N-1:0]   image_out;
  logic           image_valid;
  logic           image_ack;
  logic           frame_err;
`ifdef IMAGE_LOADER_STATS_EN
  logic [15:0]    frame_cnt;
  logic [15:0]    err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int ferr_double = 0;
  int early_valid = 0;
  logic ferr_prev = 1'b0;
  logic [N-1:0] ref_img;
  logic [N-1:0] exp_img;

  image_loader dut (
    .clk         (clk),
    .rst         (rst),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_last    (pix_last),
    .pix_ready   (pix_ready),
    .image_out   (image_out),
    .image_valid (image_valid),
    .image_ack   (image_ack),
`ifdef IMAGE_LOADER_STATS_EN
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
`else
    .frame_err   (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame_err is sampled on the inactive edge; back-to-back highs are recorded.
  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      ferr_seen++;
      if (ferr_prev) ferr_double++;
    end
    ferr_prev = (frame_err === 1'b1);
  end

  function automatic logic [7:0] pix_of(input int mode, input int k);
    case (mode)
      0:       pix_of = 8'd200;
      1:       pix_of = (k % 2 == 0) ? 8'd128 : 8'd127;
      default: pix_of = (k % 3 == 0) ? 8'd255 : 8'(k % 7);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    pix_data = 8'd0;
    image_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Streams nbeats pixels (optionally with random idle cycles).
  // pix_last is raised on the final beat when with_last is set.
  task automatic stream(input int nbeats, input int mode, input bit with_last, input bit gaps);
    int k = 0;
    int cyc = 0;
    bit v;
    early_valid = 0;
    while (k < nbeats && cyc < 5000) begin
      v = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      pix_valid = v;
      pix_data  = pix_of(mode, k);
      pix_last  = with_last && (k == nbeats - 1);
      if (image_valid !== 1'b0) early_valid++;
      @(posedge clk);
      #1;
      if (v) k++;
      cyc++;
    end
    pix_valid = 1'b0;
    pix_last = 1'b0;
    checks++;
    if (k != nbeats) begin
      errors++;
      $display("FAIL stream_budget: sent %0d beats, required %0d", k, nbeats);
    end
  endtask

  task automatic ack();
    image_ack = 1'b1;
    @(posedge clk);
    #1 image_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (image_out !== '0 || image_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: out_nz=%0b valid=%b err=%b, required 0/0/0", |image_out, image_valid, frame_err);
    end
    do_reset();
    checks++;
    if (pix_ready !== 1'b1 || image_valid !== 1'b0 || image_out !== '0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b err=%b, required 1/0/0", pix_ready, image_valid, frame_err);
    end
  endtask

  task automatic test_full_ones();
    int f0 = ferr_seen;
    stream(N, 0, 1'b1, 1'b0);
    checks++;
    if (early_valid != 0) begin
      errors++;
      $display("FAIL ones_early_valid: %0d cycles, required 0", early_valid);
    end
    checks++;
    if (image_valid !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL ones_latency: valid=%b ready=%b, required 1/0", image_valid, pix_ready);
    end
    checks++;
    if (image_out !== {N{1'b1}}) begin
      errors++;
      $display("FAIL ones_data: popcount %0d, required %0d", $countones(image_out), N);
    end
    checks++;
    if (ferr_seen != f0) begin
      errors++;
      $display("FAIL ones_frame_err: %0d pulses, required 0", ferr_seen - f0);
    end
  endtask

  task automatic test_threshold();
    ack();
    checks++;
    if (image_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_exit: valid=%b ready=%b, required 0/1", image_valid, pix_ready);
    end
    stream(N, 1, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) exp_img[k] = (k % 2 == 0);
    checks++;
    if (image_valid !== 1'b1 || image_out !== exp_img) begin
      errors++;
      $display("FAIL threshold_data: valid=%b bit0=%b bit1=%b, required 1/1/0", image_valid, image_out[0], image_out[1]);
    end
    ref_img = image_out;
  endtask

  task automatic test_hold();
    logic [N-1:0] snap = image_out;
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      pix_last  = 1'($urandom);
      @(posedge clk);
      #1;
      if (image_out !== snap || pix_ready !== 1'b0 || image_valid !== 1'b1) bad++;
    end
    pix_valid = 1'b0;
    pix_last = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d disturbed cycles, required 0", bad);
    end
    ack();
    checks++;
    if (image_valid !== 1'b0 || pix_ready !== 1'b1 || image_out !== snap) begin
      errors++;
      $display("FAIL hold_ack: valid=%b ready=%b, required 0/1", image_valid, pix_ready);
    end
    ack();
    checks++;
    if (image_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_in_load: valid=%b ready=%b, required 0/1", image_valid, pix_ready);
    end
  endtask

  task automatic test_short();
    int f0 = ferr_seen;
    stream(100, 2, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL short_err_pulse: frame_err=%b, required 1", frame_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ferr_seen - f0 != 1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL short_err_once: %0d pulses now=%b, required 1/0", ferr_seen - f0, frame_err);
    end
    checks++;
    if (image_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_state: valid=%b ready=%b, required 0/1", image_valid, pix_ready);
    end
    stream(N, 2, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) exp_img[k] = (k % 3 == 0);
    checks++;
    if (image_valid !== 1'b1 || image_out !== exp_img) begin
      errors++;
      $display("FAIL short_recover: valid=%b popcount %0d, required 1/%0d", image_valid, $countones(image_out), 262);
    end
    checks++;
    if (ferr_seen - f0 != 1) begin
      errors++;
      $display("FAIL short_total_err: %0d pulses, required 1", ferr_seen - f0);
    end
  endtask

  task automatic test_overrun();
    int f0;
    ack();
    f0 = ferr_seen;
    stream(N, 0, 1'b0, 1'b0);
    checks++;
    if (image_valid !== 1'b1 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_complete: valid=%b err=%b, required 1/1", image_valid, frame_err);
    end
    pix_valid = 1'b1;
    pix_data = 8'd0;
    repeat (2) @(posedge clk);
    #1 pix_valid = 1'b0;
    checks++;
    if (frame_err !== 1'b0 || image_out !== {N{1'b1}} || ferr_seen - f0 != 1) begin
      errors++;
      $display("FAIL overrun_after: err=%b pulses=%0d popcount=%0d, required 0/1/%0d", frame_err, ferr_seen - f0, $countones(image_out), N);
    end
    checks++;
    if (ferr_double != 0) begin
      errors++;
      $display("FAIL err_double: %0d, required 0", ferr_double);
    end
  endtask

  task automatic test_gaps();
    int f0;
    ack();
    stream(N, 1, 1'b1, 1'b1);
    checks++;
    if (image_valid !== 1'b1 || image_out !== ref_img) begin
      errors++;
      $display("FAIL gaps_data: valid=%b, image differs from gap-free run", image_valid);
    end
    ack();
    f0 = ferr_seen;
    stream(400, 1, 1'b0, 1'b1);
    checks++;
    if (image_out === '0) begin
      errors++;
      $display("FAIL gaps_partial: image_out zero after 400 beats, required nonzero");
    end
    rst = 1'b0;
    #1;
    checks++;
    if (image_out !== '0 || image_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: out_nz=%0b valid=%b err=%b, required 0/0/0", |image_out, image_valid, frame_err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (pix_ready !== 1'b1 || ferr_seen != f0) begin
      errors++;
      $display("FAIL reset_no_err: ready=%b pulses=%0d, required 1/0", pix_ready, ferr_seen - f0);
    end
    stream(N, 0, 1'b1, 1'b0);
    checks++;
    if (image_valid !== 1'b1 || image_out !== {N{1'b1}}) begin
      errors++;
      $display("FAIL first_beat_after_reset: valid=%b popcount=%0d, required 1/%0d", image_valid, $countones(image_out), N);
    end
  endtask

`ifdef IMAGE_LOADER_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: frame_cnt=%0d err_cnt=%0d, required 0/0", frame_cnt, err_cnt);
    end
    stream(N, 0, 1'b1, 1'b0);
    ack();
    stream(50, 0, 1'b1, 1'b0);
    stream(N, 2, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (frame_cnt !== 16'd2 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stats_counts: frame_cnt=%0d err_cnt=%0d, required 2/1", frame_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    pix_data = 8'd0;
    image_ack = 1'b0;
    #2;
    test_reset();
    test_full_ones();
    test_threshold();
    test_hold();
    test_short();
    test_overrun();
    test_gaps();
`ifdef IMAGE_LOADER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter IMG_DIM, default 28, image side length in pixels; N = IMG_DIM*IMG_DIM.
REQ-002 SHALL have parameter PIX_W, default 8, incoming pixel width in bits.
REQ-003 SHALL have parameter THRESHOLD, default 128, binarisation threshold (unsigned, PIX_W bits).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pix_data  input  PIX_W  unsigned grayscale pixel, raster order (row-major, row 0 first).
REQ-007 pix_valid  input  1  pix_data/pix_last valid this cycle.
REQ-008 pix_last  input  1  marks final pixel of a frame.
REQ-009 pix_ready  output  1  loader accepts a beat this cycle.
REQ-010 image_out  output  N  packed binary image for cnn_top input_image; pixel k = row*IMG_DIM+col at bit k.
REQ-011 image_valid  output  1  image_out holds a complete frame.
REQ-012 image_ack  input  1  consumer has latched image_out; frees the buffer.
REQ-013 frame_err  output  1  one-cycle pulse on framing error.

Function
REQ-014 SHALL implement two states: LOAD (pix_ready=1, image_valid=0) and HOLD (pix_ready=0, image_valid=1).
REQ-015 Beat accepted iff pix_valid && pix_ready; pix_ready SHALL be a registered state decode, not dependent on pix_valid.
REQ-016 On accepted beat, image_out[cnt] SHALL be written with (pix_data >= THRESHOLD); cnt (ceil(log2 N) bits) increments by 1.
REQ-017 Accepted beat with cnt==N-1 and pix_last=1: next cycle state=HOLD, image_valid=1, cnt=0.
REQ-018 Accepted beat with cnt==N-1 and pix_last=0: frame SHALL still complete as REQ-017 and frame_err pulses 1 cycle; subsequent beats until HOLD exit are not accepted.
REQ-019 Accepted beat with pix_last=1 and cnt<N-1 (short frame): frame_err pulses 1 cycle, cnt returns to 0, state stays LOAD, image_valid stays 0; partially written bits are don't-care and overwritten by the next frame.
REQ-020 In HOLD, image_out SHALL remain bit-stable until exit.
REQ-021 In HOLD with image_ack=1: next cycle state=LOAD, image_valid=0, pix_ready=1; image_ack in LOAD SHALL be ignored.
REQ-022 Latency: image_valid rises exactly 1 cycle after the N-th beat is accepted; sustained throughput 1 pixel/cycle in LOAD.
REQ-023 pix_valid with pix_ready=0 SHALL have no effect; upstream holds the beat.
REQ-024 frame_err SHALL never be high two consecutive cycles from a single event.

Reset
REQ-025 rst=0 SHALL immediately force state=LOAD, cnt=0, image_out=0, image_valid=0, frame_err=0; pix_ready=1 after release.
REQ-026 Reset mid-frame or in HOLD SHALL discard the frame with no frame_err pulse.
REQ-027 First beat SHALL be acceptable on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro IMAGE_LOADER_STATS_EN, when defined, SHALL add outputs frame_cnt (16 bit) and err_cnt (16 bit), both reset to 0.
REQ-029 With macro: frame_cnt increments on each LOAD->HOLD transition; err_cnt increments on each frame_err pulse; both saturate at 16'hFFFF.
REQ-030 Without macro: ports and counters absent; all other behaviour identical.

Verification
REQ-031 Reset, stream 784 beats pix_data=8'd200 back-to-back, pix_last on 784th -> image_valid=1 one cycle later, image_out all ones, pix_ready=0, frame_err never 1.
REQ-032 Stream pixel k = (k even ? 8'd128 : 8'd127) -> image_out even bits 1, odd bits 0 (threshold boundary).
REQ-033 In HOLD, drive pix_valid=1 for 10 cycles with random data, then image_ack=1 -> image_out unchanged throughout, image_valid=0 and pix_ready=1 next cycle.
REQ-034 Short frame: pix_last at beat 100 -> frame_err pulses once, image_valid stays 0; then full 784-beat frame -> valid image, correct data.
REQ-035 Random pix_valid gaps (50% duty) over a full frame -> image identical to gap-free run; rst=0 at beat 400 -> all outputs zero immediately, no frame_err.
REQ-036 With IMAGE_LOADER_STATS_EN: two good frames plus one short frame -> frame_cnt=2, err_cnt=1.
